// File: rtl/me_pkg.sv
// Shared types and default geometry for the motion-estimation frame scheduler.
// Derived constants describe the macroblock grid of one frame at default size.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } state_t;

  localparam int unsigned DEF_FRAME_WIDTH  = 352;
  localparam int unsigned DEF_FRAME_HEIGHT = 240;
  localparam int unsigned DEF_MB_SIZE      = 16;
  localparam int unsigned DEF_WDOG_LIMIT   = 50000;

  localparam int unsigned MB_COLS    = DEF_FRAME_WIDTH / DEF_MB_SIZE;
  localparam int unsigned MB_ROWS    = DEF_FRAME_HEIGHT / DEF_MB_SIZE;
  localparam int unsigned FRAME_SIZE = DEF_FRAME_WIDTH * DEF_FRAME_HEIGHT;

  typedef struct packed {
    logic [4:0]         col;
    logic [3:0]         row;
    logic signed [5:0]  mv_x;
    logic signed [5:0]  mv_y;
    logic [15:0]        sad;
  } res_t;

endpackage

// File: rtl/me_mb_counter.sv
// Raster-order macroblock column/row counter; updates one cycle after clear/advance.
// Exposes the post-advance position so callers can register it in the same edge.
module me_mb_counter
  import me_pkg::*;
#(
  parameter int unsigned COLS = MB_COLS,
  parameter int unsigned ROWS = MB_ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [4:0] col,
  output logic [3:0] row,
  output logic [4:0] col_nxt,
  output logic [3:0] row_nxt,
  output logic       last
);

  localparam logic [4:0] COL_MAX = 5'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  logic [4:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic       col_at_end;

  always_comb begin
    col_at_end = (col_q == COL_MAX);
    col_nxt    = col_at_end ? 5'd0 : col_q + 5'd1;
    row_nxt    = col_at_end ? row_q + 4'd1 : row_q;
    last       = col_at_end && (row_q == ROW_MAX);
    col_d      = col_q;
    row_d      = row_q;
    if (clear) begin
      col_d = 5'd0;
      row_d = 4'd0;
    end else if (advance) begin
      col_d = col_nxt;
      row_d = row_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= 5'd0;
      row_q <= 4'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/me_frame_sched.sv
// Walks a frame macroblock by macroblock through hexbs_top: start -> wait done edge -> emit result.
// One MB in flight; result held until res_ready, next me_start the cycle after the handshake.
module me_frame_sched
  import me_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int unsigned MB_SIZE      = DEF_MB_SIZE,
  parameter int unsigned WDOG_LIMIT   = DEF_WDOG_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_go,
  input  logic [7:0]        frame_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              err_badframe,
  output logic              me_start,
  output logic [31:0]       me_frame_start_addr,
  output logic [31:0]       me_ref_start_addr,
  output logic [31:0]       me_mb_x,
  output logic [31:0]       me_mb_y,
  input  logic              me_done,
  input  logic signed [5:0] me_mv_x,
  input  logic signed [5:0] me_mv_y,
  input  logic [15:0]       me_sad,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4:0]        res_mb_col,
  output logic [3:0]        res_mb_row,
  output logic signed [5:0] res_mv_x,
  output logic signed [5:0] res_mv_y,
  output logic [15:0]       res_sad
);

  localparam int unsigned COLS   = FRAME_WIDTH / MB_SIZE;
  localparam int unsigned ROWS   = FRAME_HEIGHT / MB_SIZE;
  localparam int unsigned FSIZE  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_badframe_q, err_badframe_d;
  logic              me_start_q, me_start_d;
  logic [31:0]       frame_base_q, frame_base_d;
  logic [31:0]       ref_base_q, ref_base_d;
  logic [31:0]       mb_x_q, mb_x_d;
  logic [31:0]       mb_y_q, mb_y_d;
  logic              done_q, done_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  res_t              res_q, res_d;
  logic              res_valid_q, res_valid_d;

  logic       cnt_clear, cnt_advance, cnt_last;
  logic [4:0] cnt_col, cnt_col_nxt;
  logic [3:0] cnt_row, cnt_row_nxt;

  me_mb_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_mb_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .col     (cnt_col),
    .row     (cnt_row),
    .col_nxt (cnt_col_nxt),
    .row_nxt (cnt_row_nxt),
    .last    (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    frame_done_d   = 1'b0;
    err_timeout_d  = err_timeout_q;
    err_badframe_d = err_badframe_q;
    me_start_d     = 1'b0;
    frame_base_d   = frame_base_q;
    ref_base_d     = ref_base_q;
    mb_x_d         = mb_x_q;
    mb_y_d         = mb_y_q;
    done_d         = me_done;
    wdog_d         = wdog_q;
    res_d          = res_q;
    res_valid_d    = res_valid_q;
    cnt_clear      = 1'b0;
    cnt_advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_go) begin
          if (frame_idx != 8'd0) begin
            err_timeout_d  = 1'b0;
            err_badframe_d = 1'b0;
            frame_base_d   = 32'(frame_idx) * 32'(FSIZE);
            ref_base_d     = (32'(frame_idx) - 32'd1) * 32'(FSIZE);
            mb_x_d         = 32'd0;
            mb_y_d         = 32'd0;
            cnt_clear      = 1'b1;
            busy_d         = 1'b1;
            me_start_d     = 1'b1;
            state_d        = ST_ISSUE;
          end else begin
            err_badframe_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A level already high on entry is left over from the previous MB.
        if (me_done && !done_q) begin
          res_d.col   = cnt_col;
          res_d.row   = cnt_row;
          res_d.mv_x  = me_mv_x;
          res_d.mv_y  = me_mv_y;
          res_d.sad   = me_sad;
          res_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          wdog_d        = wdog_q + 1'b1;
          err_timeout_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (cnt_last) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            cnt_advance = 1'b1;
            mb_x_d      = 32'(cnt_col_nxt) * 32'(MB_SIZE);
            mb_y_d      = 32'(cnt_row_nxt) * 32'(MB_SIZE);
            me_start_d  = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_badframe_q <= 1'b0;
      me_start_q     <= 1'b0;
      frame_base_q   <= 32'd0;
      ref_base_q     <= 32'd0;
      mb_x_q         <= 32'd0;
      mb_y_q         <= 32'd0;
      done_q         <= 1'b0;
      wdog_q         <= '0;
      res_q          <= '0;
      res_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      err_timeout_q  <= err_timeout_d;
      err_badframe_q <= err_badframe_d;
      me_start_q     <= me_start_d;
      frame_base_q   <= frame_base_d;
      ref_base_q     <= ref_base_d;
      mb_x_q         <= mb_x_d;
      mb_y_q         <= mb_y_d;
      done_q         <= done_d;
      wdog_q         <= wdog_d;
      res_q          <= res_d;
      res_valid_q    <= res_valid_d;
    end
  end

  assign busy                = busy_q;
  assign frame_done          = frame_done_q;
  assign err_timeout         = err_timeout_q;
  assign err_badframe        = err_badframe_q;
  assign me_start            = me_start_q;
  assign me_frame_start_addr = frame_base_q;
  assign me_ref_start_addr   = ref_base_q;
  assign me_mb_x             = mb_x_q;
  assign me_mb_y             = mb_y_q;
  assign res_valid           = res_valid_q;
  assign res_mb_col          = res_q.col;
  assign res_mb_row          = res_q.row;
  assign res_mv_x            = res_q.mv_x;
  assign res_mv_y            = res_q.mv_y;
  assign res_sad             = res_q.sad;

endmodule

// File: tb/tb_me_frame_sched.sv
// Directed bench for me_frame_sched with a behavioural hexbs_top responder.
// Responder modes: 0 = done 5 cycles after start, 1 = stale-high done, 2 = never done.
module tb_me_frame_sched;

  logic              clk;
  logic              rst;
  logic              frame_go;
  logic [7:0]        frame_idx;
  logic              busy, frame_done, err_timeout, err_badframe, me_start;
  logic [31:0]       me_frame_start_addr, me_ref_start_addr, me_mb_x, me_mb_y;
  logic              me_done;
  logic signed [5:0] me_mv_x, me_mv_y;
  logic [15:0]       me_sad;
  logic              res_valid, res_ready;
  logic [4:0]        res_mb_col;
  logic [3:0]        res_mb_row;
  logic signed [5:0] res_mv_x, res_mv_y;
  logic [15:0]       res_sad;

  me_frame_sched dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_go            (frame_go),
    .frame_idx           (frame_idx),
    .busy                (busy),
    .frame_done          (frame_done),
    .err_timeout         (err_timeout),
    .err_badframe        (err_badframe),
    .me_start            (me_start),
    .me_frame_start_addr (me_frame_start_addr),
    .me_ref_start_addr   (me_ref_start_addr),
    .me_mb_x             (me_mb_x),
    .me_mb_y             (me_mb_y),
    .me_done             (me_done),
    .me_mv_x             (me_mv_x),
    .me_mv_y             (me_mv_y),
    .me_sad              (me_sad),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_mb_col          (res_mb_col),
    .res_mb_row          (res_mb_row),
    .res_mv_x            (res_mv_x),
    .res_mv_y            (res_mv_y),
    .res_sad             (res_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] fa, ra, x, y;
  } start_t;

  typedef struct {
    int          cyc;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [5:0]  mvx, mvy;
    logic [15:0] sad;
  } res_rec_t;

  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc = 0;
  int       mode = 0;
  int       since_start = 100;
  int       done_cnt = 0;
  int       done_cyc = 0;
  logic     done_busy = 1'b0;
  start_t   starts[$];
  res_rec_t results[$];

  // One clock: log a handshake about to happen, step, then sample and run the responder.
  task automatic tick();
    res_rec_t r;
    start_t   s;
    int       k;
    if (res_valid && res_ready && !rst) begin
      r.cyc = cyc; r.col = res_mb_col; r.row = res_mb_row;
      r.mvx = res_mv_x; r.mvy = res_mv_y; r.sad = res_sad;
      results.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (me_start) begin
      s.cyc = cyc; s.fa = me_frame_start_addr; s.ra = me_ref_start_addr;
      s.x = me_mb_x; s.y = me_mb_y;
      starts.push_back(s);
      since_start = 0;
      if (mode == 0) me_done = 1'b0;
    end else begin
      since_start++;
    end
    k = starts.size() - 1;
    case (mode)
      0: if (since_start == 5) begin
        me_done = 1'b1;
        me_mv_x = 6'(k * 3); me_mv_y = 6'(k * 7 + 1); me_sad = 16'(k * 11 + 2);
      end
      1: if (since_start == 2) begin
        me_done = 1'b0;
      end else if (since_start == 4) begin
        me_done = 1'b1;
        me_mv_x = 6'(k * 3); me_mv_y = 6'(k * 7 + 1); me_sad = 16'(k * 11 + 2);
      end
      default: me_done = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_go = 1'b0; frame_idx = 8'd0; res_ready = 1'b1; me_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    starts.delete(); results.delete();
    done_cnt = 0; since_start = 100;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_go = 1'b0; frame_idx = 8'd0; res_ready = 1'b1; me_done = 1'b0;
    me_mv_x = '0; me_mv_y = '0; me_sad = '0;
    tick(); tick();
    n_tests++;
    if ({busy, frame_done, err_timeout, err_badframe, me_start, res_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                         {busy, frame_done, err_timeout, err_badframe, me_start, res_valid});
    end
    rst = 1'b0; mode = 0;
    frame_go = 1'b1; frame_idx = 8'd2;
    tick();
    frame_go = 1'b0;
    n_tests++;
    if ({me_start, busy} !== 2'b11) begin
      n_fail++; $display("FAIL start_latency: me_start,busy got %b expected 11", {me_start, busy});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({busy, frame_done, err_timeout, err_badframe, me_start, res_valid} !== 6'b0) begin
      n_fail++; $display("FAIL midwait_reset_flags: got %b expected 000000",
                         {busy, frame_done, err_timeout, err_badframe, me_start, res_valid});
    end
    n_tests++;
    if ({me_frame_start_addr, me_ref_start_addr, me_mb_x, me_mb_y} !== 128'b0) begin
      n_fail++; $display("FAIL midwait_reset_addr: got %h %h %h %h expected all 0",
                         me_frame_start_addr, me_ref_start_addr, me_mb_x, me_mb_y);
    end
    n_tests++;
    if ({res_mb_col, res_mb_row, res_mv_x, res_mv_y, res_sad} !== 37'b0) begin
      n_fail++; $display("FAIL midwait_reset_payload: got %h expected 0",
                         {res_mb_col, res_mb_row, res_mv_x, res_mv_y, res_sad});
    end
    rst = 1'b0;
    frame_go = 1'b1; frame_idx = 8'd4;
    tick();
    frame_go = 1'b0;
    n_tests++;
    if ({me_start, me_mb_x, me_mb_y} !== {1'b1, 64'd0}) begin
      n_fail++; $display("FAIL restart_mb00: me_start=%b x=%0d y=%0d expected 1,0,0", me_start, me_mb_x, me_mb_y);
    end
    n_tests++;
    if (me_frame_start_addr !== 32'd337920 || me_ref_start_addr !== 32'd253440) begin
      n_fail++; $display("FAIL restart_bases: got %0d/%0d expected 337920/253440",
                         me_frame_start_addr, me_ref_start_addr);
    end
  endtask

  task automatic test_full_frame();
    int bad_pos, bad_base, bad_res, bad_tim, last;
    do_reset();
    mode = 0;
    frame_go = 1'b1; frame_idx = 8'd2;
    tick();
    frame_go = 1'b0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (starts.size() != 330) begin n_fail++; $display("FAIL frame_starts: got %0d expected 330", starts.size()); end
    n_tests++;
    if (results.size() != 330) begin n_fail++; $display("FAIL frame_results: got %0d expected 330", results.size()); end
    n_tests++;
    if (done_cnt != 1 || done_busy !== 1'b0) begin
      n_fail++; $display("FAIL frame_done_pulse: count %0d busy %b expected 1 and 0", done_cnt, done_busy);
    end
    bad_pos = 0; bad_base = 0; bad_res = 0; bad_tim = 0;
    foreach (starts[i]) begin
      if (starts[i].x !== 32'((i % 22) * 16) || starts[i].y !== 32'((i / 22) * 16)) bad_pos++;
      if (starts[i].fa !== 32'd168960 || starts[i].ra !== 32'd84480) bad_base++;
    end
    foreach (results[i]) begin
      if (results[i].col !== 5'(i % 22) || results[i].row !== 4'(i / 22) ||
          results[i].mvx !== 6'(i * 3) || results[i].mvy !== 6'(i * 7 + 1) ||
          results[i].sad !== 16'(i * 11 + 2)) bad_res++;
      if (i + 1 < starts.size() && starts[i + 1].cyc != results[i].cyc + 1) bad_tim++;
    end
    last = starts.size() - 1;
    n_tests++;
    if (last >= 0 && (starts[last].x !== 32'd336 || starts[last].y !== 32'd224)) begin
      n_fail++; $display("FAIL frame_last_mb: got x=%0d y=%0d expected 336,224", starts[last].x, starts[last].y);
    end
    n_tests++;
    if (bad_pos != 0) begin n_fail++; $display("FAIL frame_positions: %0d wrong, expected 0", bad_pos); end
    n_tests++;
    if (bad_base != 0) begin n_fail++; $display("FAIL frame_bases: %0d wrong, expected 0", bad_base); end
    n_tests++;
    if (bad_res != 0) begin n_fail++; $display("FAIL frame_raster_payload: %0d wrong, expected 0", bad_res); end
    n_tests++;
    if (bad_tim != 0) begin n_fail++; $display("FAIL frame_restart_timing: %0d wrong, expected 0", bad_tim); end
    last = results.size() - 1;
    n_tests++;
    if (last >= 0 && done_cyc != results[last].cyc + 1) begin
      n_fail++; $display("FAIL frame_done_timing: got cycle %0d expected %0d", done_cyc, results[last].cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] snap;
    int          ns, bad;
    do_reset();
    mode = 0; res_ready = 1'b0;
    frame_go = 1'b1; frame_idx = 8'd1;
    tick();
    frame_go = 1'b0;
    for (int i = 0; i < 50 && !res_valid; i++) tick();
    snap = {res_mb_col, res_mb_row, res_mv_x, res_mv_y, res_sad};
    n_tests++;
    if ({res_valid, snap} !== {1'b1, 5'd0, 4'd0, 6'd0, 6'd1, 16'd2}) begin
      n_fail++; $display("FAIL bp_first_payload: valid=%b payload=%h expected 1, %h",
                         res_valid, snap, {5'd0, 4'd0, 6'd0, 6'd1, 16'd2});
    end
    ns = starts.size(); bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!res_valid || {res_mb_col, res_mb_row, res_mv_x, res_mv_y, res_sad} !== snap || me_start) bad++;
    end
    n_tests++;
    if (bad != 0 || starts.size() != ns || results.size() != 0) begin
      n_fail++; $display("FAIL bp_hold: %0d unstable cycles, %0d extra starts, %0d results, expected 0/0/0",
                         bad, starts.size() - ns, results.size());
    end
    res_ready = 1'b1;
    tick();
    n_tests++;
    if ({me_start, res_valid} !== 2'b10 || starts.size() != ns + 1 || me_mb_x !== 32'd16) begin
      n_fail++; $display("FAIL bp_release: me_start,res_valid=%b x=%0d expected 10, x=16", {me_start, res_valid}, me_mb_x);
    end
  endtask

  task automatic test_stale_done();
    int bad;
    do_reset();
    mode = 1; me_done = 1'b1;
    frame_go = 1'b1; frame_idx = 8'd3;
    tick();
    frame_go = 1'b0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    bad = 0;
    foreach (results[i])
      if (results[i].col !== 5'(i % 22) || results[i].row !== 4'(i / 22) || results[i].sad !== 16'(i * 11 + 2)) bad++;
    n_tests++;
    if (starts.size() != 330 || results.size() != 330 || done_cnt != 1) begin
      n_fail++; $display("FAIL stale_counts: starts %0d results %0d done %0d expected 330/330/1",
                         starts.size(), results.size(), done_cnt);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stale_one_per_mb: %0d wrong results, expected 0", bad); end
  endtask

  task automatic test_timeout();
    int s_cyc;
    do_reset();
    mode = 2;
    frame_go = 1'b1; frame_idx = 8'd5;
    tick();
    frame_go = 1'b0;
    s_cyc = cyc;
    for (int i = 0; i < 50100 && busy; i++) tick();
    n_tests++;
    if (cyc != s_cyc + 50001) begin
      n_fail++; $display("FAIL timeout_cycle: busy dropped at +%0d expected +50001", cyc - s_cyc);
    end
    n_tests++;
    if ({err_timeout, busy, res_valid} !== 3'b100 || done_cnt != 0 || starts.size() != 1) begin
      n_fail++; $display("FAIL timeout_state: err,busy,valid=%b done %0d starts %0d expected 100, 0, 1",
                         {err_timeout, busy, res_valid}, done_cnt, starts.size());
    end
  endtask

  task automatic test_bad_overlap();
    starts.delete(); results.delete();
    frame_go = 1'b1; frame_idx = 8'd0;
    tick();
    frame_go = 1'b0;
    tick(); tick();
    n_tests++;
    if ({err_badframe, err_timeout, busy} !== 3'b110 || starts.size() != 0) begin
      n_fail++; $display("FAIL badframe: badf,tmo,busy=%b starts %0d expected 110, 0",
                         {err_badframe, err_timeout, busy}, starts.size());
    end
    mode = 0;
    frame_go = 1'b1; frame_idx = 8'd3;
    tick();
    frame_go = 1'b0;
    n_tests++;
    if ({err_badframe, err_timeout, busy, me_start} !== 4'b0011 ||
        me_frame_start_addr !== 32'd253440 || me_ref_start_addr !== 32'd168960) begin
      n_fail++; $display("FAIL accept_clears: flags=%b bases %0d/%0d expected 0011, 253440/168960",
                         {err_badframe, err_timeout, busy, me_start}, me_frame_start_addr, me_ref_start_addr);
    end
    tick(); tick();
    frame_go = 1'b1; frame_idx = 8'd7;
    tick();
    frame_go = 1'b0;
    n_tests++;
    if (me_start !== 1'b0 || me_frame_start_addr !== 32'd253440 || me_ref_start_addr !== 32'd168960) begin
      n_fail++; $display("FAIL overlap_ignored: me_start=%b bases %0d/%0d expected 0, 253440/168960",
                         me_start, me_frame_start_addr, me_ref_start_addr);
    end
    for (int i = 0; i < 50 && starts.size() < 2; i++) tick();
    n_tests++;
    if (starts.size() != 2 || starts[1].x !== 32'd16 || starts[1].y !== 32'd0 || starts[1].fa !== 32'd253440) begin
      n_fail++; $display("FAIL overlap_continue: starts %0d second x=%0d y=%0d expected 2, 16, 0",
                         starts.size(), starts[starts.size() - 1].x, starts[starts.size() - 1].y);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_stale_done();
    test_timeout();
    test_bad_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
